axi4lite_reg_slave: RTL

AXI4-Lite responder that exposes a bank of `NUM_REGS` read/write control registers to an AXI4-Lite master. It is the slave end of the `axi4lite_if` bus and sits between the SoC interconnect and peripheral control logic. The bank drives the register contents and a per-register write strobe to the fabric. The AW/W, B, AR and R channels are handled by two independent state machines.

---
 rtl/axi4lite_reg_slave.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave
// AXI4-Lite slave exposing NUM_REGS read/write control registers.
// Write (AW/W/B) and read (AR/R) channels run two independent FSMs.
// Every bus output is a flop, so no output depends combinationally on a
// VALID or READY input.
//
// Ports:
//   ACLK, ARESET                        clock, asynchronous active-high reset
//   AWADDR/AWPROT/AWVALID/AWREADY       write address channel (AWPROT ignored)
//   WDATA/WSTRB/WVALID/WREADY           write data channel
//   BRESP/BVALID/BREADY                 write response channel
//   ARADDR/ARPROT/ARVALID/ARREADY       read address channel (ARPROT ignored)
//   RDATA/RRESP/RVALID/RREADY           read data channel
//   reg_q                               register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                              one-cycle pulse per register write
module axi4lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [2:0]                   AWPROT,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [STRB_WIDTH-1:0]        WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_WIDTH-1:0]        ARADDR,
  input  logic [2:0]                   ARPROT,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_WIDTH-1:0]        RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  localparam int OFF = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] NREGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;

  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];

  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [NUM_REGS-1:0]   reg_wr_q, wr_onehot;

  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_in_range, rd_in_range;

  logic unused_ok;
  assign unused_ok = &{1'b0, AWPROT, ARPROT};

  assign aw_hs = AWVALID && awready_q;
  assign w_hs  = WVALID && wready_q;
  assign ar_hs = ARVALID && arready_q;

  // The committing beat takes whichever half was captured earlier from the
  // holding flops and the other half straight from the bus.
  assign wr_addr     = (wstate_q == W_HAVE_AW) ? awaddr_q : AWADDR;
  assign wr_data     = (wstate_q == W_HAVE_W) ? wdata_q : WDATA;
  assign wr_strb     = (wstate_q == W_HAVE_W) ? wstrb_q : WSTRB;
  assign wr_idx      = wr_addr >> OFF;
  assign wr_in_range = wr_idx < NREGS_A;
  assign rd_idx      = ARADDR >> OFF;
  assign rd_in_range = rd_idx < NREGS_A;

  // Write FSM: next state and next-cycle output values.
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_HAVE_W: if (aw_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_RESP: if (bvalid_q && BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    if (commit) bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
    bvalid_d  = (wstate_d == W_RESP);
    wr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_onehot[i] = commit && wr_in_range && (wr_idx == ADDR_WIDTH'(i));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      reg_wr_q  <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      reg_wr_q  <= wr_onehot;
      if (aw_hs) awaddr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
    end
  end

  // Register bank: byte lanes without a strobe bit keep their value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_onehot[i])
          for (int b = 0; b < STRB_WIDTH; b++)
            if (wr_strb[b]) bank_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Read mux samples the bank before any same-edge write lands, so a
  // colliding read returns the old value. Out-of-range indices match nothing.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == ADDR_WIDTH'(i)) rd_mux = bank_q[i];
  end

  // Read FSM: next state and next-cycle output values.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d = R_DATA;
        rdata_d  = rd_mux;
        rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      R_DATA: if (rvalid_q && RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign reg_wr  = reg_wr_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regq
    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = bank_q[gi];
  end

endmodule
